// File: rtl/rvv_issue_sequencer_if.sv
// ============================================================================
// Module  : rvv_issue_sequencer_if
// Purpose : Instruction-accept and beat-issue signals of the RVV issue sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rvv_issue_sequencer_if #(
    parameter int OPW = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_vd;
    logic [4:0]      in_vs1;
    logic [4:0]      in_vs2;
    logic [OPW-1:0]  in_op;
    logic [2:0]      in_vsew;
    logic [31:0]     in_vl;
    logic            kill;
    logic            iss_valid;
    logic            iss_ready;
    logic [4:0]      iss_vd;
    logic [4:0]      iss_vs1;
    logic [4:0]      iss_vs2;
    logic [OPW-1:0]  iss_op;
    logic [6:0]      iss_elem_cnt;
    logic            iss_last;
    logic            done;
    logic            err;
    logic            busy;

    modport slave (
        input  in_valid, in_vd, in_vs1, in_vs2, in_op, in_vsew, in_vl, kill, iss_ready,
        output in_ready, iss_valid, iss_vd, iss_vs1, iss_vs2, iss_op, iss_elem_cnt,
               iss_last, done, err, busy
    );

    modport master (
        output in_valid, in_vd, in_vs1, in_vs2, in_op, in_vsew, in_vl, kill, iss_ready,
        input  in_ready, iss_valid, iss_vd, iss_vs1, iss_vs2, iss_op, iss_elem_cnt,
               iss_last, done, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/rvv_issue_sequencer.sv
// ============================================================================
// Module  : rvv_issue_sequencer
// Purpose : Splits one LMUL-grouped vector instruction into per-register beats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rvv_issue_sequencer #(
    parameter int VLEN = 512,
    parameter int OPW  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    rvv_issue_sequencer_if.slave  bus
);
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;
    localparam logic [1:0] C_ERR   = 2'd3;

    // Elements per register; codes above 3 never reach ISSUE, so their value is irrelevant.
    function automatic logic [31:0] epr_of(input logic [2:0] sew);
        case (sew)
            3'd0:    epr_of = 32'(VLEN / 8);
            3'd1:    epr_of = 32'(VLEN / 16);
            3'd2:    epr_of = 32'(VLEN / 32);
            default: epr_of = 32'(VLEN / 64);
        endcase
    endfunction

    logic [1:0]     state_q, state_d;
    logic [4:0]     vd_q, vd_d;
    logic [4:0]     vs1_q, vs1_d;
    logic [4:0]     vs2_q, vs2_d;
    logic [OPW-1:0] op_q, op_d;
    logic [2:0]     vsew_q, vsew_d;
    logic [31:0]    rem_q, rem_d;
    logic [4:0]     beat_q, beat_d;

    logic [31:0]    w_epr_in;
    logic [31:0]    w_vlmax_in;
    logic [31:0]    w_rem_in;
    logic [31:0]    w_epr;
    logic           w_last;
    logic [6:0]     w_cnt;

    // A beat never exceeds EPR elements, so the 7-bit count holds for VLEN up to 512.
    always_comb begin
        w_epr_in   = epr_of(bus.in_vsew);
        w_vlmax_in = w_epr_in << 3;
        w_rem_in   = (bus.in_vl > w_vlmax_in) ? w_vlmax_in : bus.in_vl;
        w_epr      = epr_of(vsew_q);
        w_last     = (rem_q <= w_epr);
        w_cnt      = w_last ? rem_q[6:0] : w_epr[6:0];
    end

    always_comb begin
        state_d = state_q;
        vd_d    = vd_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        op_d    = op_q;
        vsew_d  = vsew_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        case (state_q)
            C_IDLE: begin
                if (bus.in_valid) begin
                    vd_d   = bus.in_vd;
                    vs1_d  = bus.in_vs1;
                    vs2_d  = bus.in_vs2;
                    op_d   = bus.in_op;
                    vsew_d = bus.in_vsew;
                    rem_d  = w_rem_in;
                    beat_d = 5'd0;
                    if (bus.in_vsew > 3'd3) begin
                        state_d = C_ERR;
                    end else if (w_rem_in == 32'd0) begin
                        state_d = C_DONE;
                    end else begin
                        state_d = C_ISSUE;
                    end
                end
            end
            C_ISSUE: begin
                if (bus.iss_ready) begin
                    rem_d  = rem_q - {25'd0, w_cnt};
                    beat_d = beat_q + 5'd1;
                end
                // Abort wins over a simultaneous last-beat completion: no done pulse.
                if (bus.kill) begin
                    state_d = C_IDLE;
                end else if (bus.iss_ready && w_last) begin
                    state_d = C_DONE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= C_IDLE;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            op_q    <= '0;
            vsew_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            vd_q    <= vd_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            op_q    <= op_d;
            vsew_q  <= vsew_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.in_ready     = (state_q == C_IDLE);
    assign bus.busy         = (state_q != C_IDLE);
    assign bus.iss_valid    = (state_q == C_ISSUE);
    assign bus.iss_last     = (state_q == C_ISSUE) && w_last;
    assign bus.iss_elem_cnt = (state_q == C_ISSUE) ? w_cnt : 7'd0;
    assign bus.iss_vd       = vd_q + beat_q;
    assign bus.iss_vs1      = vs1_q + beat_q;
    assign bus.iss_vs2      = vs2_q + beat_q;
    assign bus.iss_op       = op_q;
    assign bus.done         = (state_q == C_DONE) || (state_q == C_ERR);
    assign bus.err          = (state_q == C_ERR);

endmodule

`default_nettype wire

// File: tb/tb_rvv_issue_sequencer.sv
// ============================================================================
// Module  : tb_rvv_issue_sequencer
// Purpose : Scoreboard bench for rvv_issue_sequencer with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvv_issue_sequencer;
    logic clk;
    logic rst_n;

    rvv_issue_sequencer_if #(.OPW(6)) bus ();

    rvv_issue_sequencer #(.VLEN(512), .OPW(6)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [5:0] op;
        logic [6:0] cnt;
        logic       last;
    } beat_t;

    beat_t exp_beats[$];
    bit    exp_err[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected-response model: pushes up to max_beats beats and the completion event.
    task automatic push_expect(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                               input logic [5:0] op, input logic [2:0] vsew, input int unsigned vl,
                               input int max_beats);
        int unsigned epr, rem, cnt;
        int          i;
        beat_t       b;
        if (vsew > 3'd3) begin
            exp_err.push_back(1'b1);
        end else begin
            epr = 64 >> vsew;
            rem = (vl > 8 * epr) ? 8 * epr : vl;
            i   = 0;
            while (rem > 0) begin
                cnt = (rem < epr) ? rem : epr;
                if (i < max_beats) begin
                    b.vd   = vd + 5'(i);
                    b.vs1  = vs1 + 5'(i);
                    b.vs2  = vs2 + 5'(i);
                    b.op   = op;
                    b.cnt  = 7'(cnt);
                    b.last = (rem <= epr);
                    exp_beats.push_back(b);
                end
                rem = rem - cnt;
                i++;
            end
            if (max_beats >= i) exp_err.push_back(1'b0);
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!bus.in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Returns #1 after the accepting edge T, i.e. inside cycle T+1.
    task automatic send(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                        input logic [5:0] op, input logic [2:0] vsew, input int unsigned vl,
                        input int max_beats);
        push_expect(vd, vs1, vs2, op, vsew, vl, max_beats);
        @(negedge clk);
        wait_ready(100);
        bus.in_vd    = vd;
        bus.in_vs1   = vs1;
        bus.in_vs2   = vs2;
        bus.in_op    = op;
        bus.in_vsew  = vsew;
        bus.in_vl    = vl;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake / completion pulse.
    logic  prev_stall;
    beat_t prev_beat;
    beat_t cur_beat;
    beat_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur_beat = '{bus.iss_vd, bus.iss_vs1, bus.iss_vs2, bus.iss_op, bus.iss_elem_cnt, bus.iss_last};
            chk("valid_vs_done_err", 32'(bus.iss_valid && (bus.done || bus.err)), 32'd0);
            if (!bus.iss_valid) chk("idle_cnt_last", 32'({bus.iss_last, bus.iss_elem_cnt}), 32'd0);
            if (prev_stall) chk("stall_hold", 32'(cur_beat), 32'(prev_beat));
            if (bus.iss_valid && bus.iss_ready) begin
                if (exp_beats.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_beats.pop_front();
                    chk("beat_vd",   32'(bus.iss_vd),       32'(e.vd));
                    chk("beat_vs1",  32'(bus.iss_vs1),      32'(e.vs1));
                    chk("beat_vs2",  32'(bus.iss_vs2),      32'(e.vs2));
                    chk("beat_op",   32'(bus.iss_op),       32'(e.op));
                    chk("beat_cnt",  32'(bus.iss_elem_cnt), 32'(e.cnt));
                    chk("beat_last", 32'(bus.iss_last),     32'(e.last));
                end
            end
            if (bus.done) begin
                if (exp_err.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else                     chk("done_err_flag", 32'(bus.err), 32'(exp_err.pop_front()));
            end else if (bus.err) begin
                chk("err_without_done", 32'd1, 32'd0);
            end
            prev_stall = bus.iss_valid && !bus.iss_ready;
            prev_beat  = cur_beat;
        end
    end

    task automatic wait_idle(input int budget);
        @(negedge clk);
        wait_ready(budget);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_busy"},     32'(bus.busy),     32'd0);
        chk({tag, "_valid"},    32'(bus.iss_valid), 32'd0);
        chk({tag, "_last"},     32'(bus.iss_last), 32'd0);
        chk({tag, "_cnt"},      32'(bus.iss_elem_cnt), 32'd0);
        chk({tag, "_done"},     32'(bus.done), 32'd0);
        chk({tag, "_err"},      32'(bus.err), 32'd0);
        chk({tag, "_fields"},   32'({bus.iss_vd, bus.iss_vs1, bus.iss_vs2, bus.iss_op}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vd     = '0;
        bus.in_vs1    = '0;
        bus.in_vs2    = '0;
        bus.in_op     = '0;
        bus.in_vsew   = '0;
        bus.in_vl     = '0;
        bus.kill      = 1'b0;
        bus.iss_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // Nominal: SEW32, vl=40 -> beats of 16,16,8.
        send(5'd8, 5'd16, 5'd24, 6'd5, 3'd2, 40, 99);
        @(negedge clk);
        chk("nom_b1_valid", 32'(bus.iss_valid), 32'd1);
        chk("nom_b1_cnt", 32'(bus.iss_elem_cnt), 32'd16);
        chk("nom_b1_vd", 32'(bus.iss_vd), 32'd8);
        @(negedge clk);
        chk("nom_b2_vd_vs2", 32'({bus.iss_vd, bus.iss_vs2}), 32'({5'd9, 5'd25}));
        chk("nom_b2_last", 32'(bus.iss_last), 32'd0);
        @(negedge clk);
        chk("nom_b3_cnt", 32'(bus.iss_elem_cnt), 32'd8);
        chk("nom_b3_vd_vs2", 32'({bus.iss_vd, bus.iss_vs2}), 32'({5'd10, 5'd26}));
        chk("nom_b3_last", 32'(bus.iss_last), 32'd1);
        @(negedge clk);
        chk("nom_done", 32'({bus.done, bus.iss_valid, bus.in_ready}), 32'b100);
        @(negedge clk);
        chk("nom_ready_again", 32'({bus.in_ready, bus.done}), 32'b10);

        // Zero length, with kill held through DONE to confirm it is ignored there.
        send(5'd3, 5'd4, 5'd5, 6'd1, 3'd0, 0, 99);
        bus.kill = 1'b1;
        @(negedge clk);
        chk("zero_done", 32'({bus.done, bus.err, bus.iss_valid}), 32'b100);
        @(negedge clk);
        chk("zero_ready", 32'(bus.in_ready), 32'd1);
        bus.kill = 1'b0;

        // Illegal SEW.
        send(5'd1, 5'd2, 5'd3, 6'd2, 3'd5, 10, 99);
        @(negedge clk);
        chk("ill_err_done", 32'({bus.err, bus.done, bus.iss_valid}), 32'b110);
        @(negedge clk);
        chk("ill_ready", 32'(bus.in_ready), 32'd1);

        // Clamp and wrap: 1000 elements at SEW8 clamps to 8 x 64, vd 28..31,0..3.
        send(5'd28, 5'd0, 5'd4, 6'd3, 3'd0, 1000, 99);
        repeat (4) @(negedge clk);
        chk("clamp_b4_vd", 32'({bus.iss_vd, bus.iss_elem_cnt}), 32'({5'd31, 7'd64}));
        @(negedge clk);
        chk("clamp_b5_wrap", 32'(bus.iss_vd), 32'd0);
        wait_idle(20);

        // Backpressure on beat 2 for three cycles.
        send(5'd8, 5'd16, 5'd24, 6'd7, 3'd2, 40, 99);
        @(posedge clk);
        #1 bus.iss_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_b2_still", 32'({bus.iss_valid, bus.iss_vd}), 32'({1'b1, 5'd9}));
        bus.iss_ready = 1'b1;
        wait_idle(20);

        // Kill during beat 2: beat 2 handshakes, beat 3 never appears, no done.
        send(5'd0, 5'd1, 5'd2, 6'd9, 3'd2, 40, 2);
        @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        @(negedge clk);
        chk("kill_idle", 32'({bus.in_ready, bus.busy, bus.iss_valid, bus.done}), 32'b1000);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-instruction.
        bus.iss_ready = 1'b0;
        send(5'd4, 5'd5, 5'd6, 6'd11, 3'd1, 100, 0);
        @(negedge clk);
        chk("rst_pre_valid", 32'(bus.iss_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus.iss_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'({bus.in_ready, bus.done}), 32'b10);

        chk("beats_left", 32'(exp_beats.size()), 32'd0);
        chk("done_left", 32'(exp_err.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/rvv_issue_sequencer.md
RVV_ISSUE_SEQUENCER -- requirements
Module: rvv_issue_sequencer

Interface
REQ-001 SHALL have parameters: VLEN, default 512, vector register width in bits; OPW, default 6, width of the passthrough ALU opcode.
REQ-002 SHALL have ports, in this order:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  decoded vector instruction offered.
- in_ready  output  1  sequencer accepts instruction.
- in_vd, in_vs1, in_vs2  input  5 each  base register indices of the LMUL group.
- in_op  input  OPW  ALU opcode; passed through unchanged.
- in_vsew  input  3  SEW code.
- in_vl  input  32  requested vector length in elements.
- kill  input  1  synchronous abort of the current instruction.
- iss_valid  output  1  beat offered to the ALU.
- iss_ready  input  1  ALU accepts the beat.
- iss_vd, iss_vs1, iss_vs2  output  5 each  register indices for this beat.
- iss_op  output  OPW  latched opcode.
- iss_elem_cnt  output  7  active elements in this beat (1..64).
- iss_last  output  1  final beat of the instruction.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle illegal-SEW pulse.
- busy  output  1  state is not IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, DONE, ERR; in_ready = (state==IDLE); busy = (state!=IDLE).
REQ-004 SHALL accept an instruction on the rising edge where in_valid && in_ready, and SHALL latch vd, vs1, vs2, op and vsew.
REQ-005 SHALL compute EPR = VLEN/SEW for vsew 0..3 (SEW 8/16/32/64, giving EPR 64/32/16/8 at VLEN=512).
REQ-006 SHALL compute rem = min(in_vl, 8*EPR) at accept; in_vl above the LMUL=8 VLMAX is clamped with no error.
REQ-007 On accept, the next state SHALL be:
- ERR if vsew > 3;
- else DONE if rem == 0;
- else ISSUE.
REQ-008 In ISSUE, the outputs SHALL be:
- iss_valid = 1;
- iss_elem_cnt = min(rem, EPR);
- iss_last = (rem <= EPR);
- iss_vd/vs1/vs2 = base + beat index, modulo 32 (5-bit wrap).
REQ-009 A beat SHALL complete only on iss_valid && iss_ready; on completion, rem decrements by iss_elem_cnt and the beat index increments.
REQ-010 While iss_valid && !iss_ready, all iss_* outputs SHALL hold stable.
REQ-011 Completion of the iss_last beat SHALL move the FSM to DONE.
REQ-012 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-013 ERR SHALL assert err and done for exactly one cycle, then return to IDLE.
REQ-014 Latency: accept at edge T -> first beat valid in cycle T+1.
REQ-015 Throughput and completion with iss_ready held high: one beat per cycle; n beats occupy T+1..T+n; done in T+n+1; in_ready high again in T+n+2.
REQ-016 kill asserted in ISSUE SHALL move the FSM to IDLE at the next edge, with no done pulse; a beat handshaking in that same cycle counts as issued.
REQ-017 kill SHALL be ignored in IDLE, DONE and ERR.
REQ-018 Outside ISSUE, iss_valid and iss_last SHALL be 0 and iss_elem_cnt SHALL be 0.
REQ-019 done, err and iss_valid SHALL never be asserted in the same cycle.

Reset
REQ-020 Asserting rst (low) SHALL immediately force IDLE, including mid-instruction; the in-flight instruction is discarded and no done is issued.
REQ-021 Reset values SHALL be: in_ready=1; iss_valid=0, iss_last=0, done=0, err=0, busy=0; iss_elem_cnt=0; all latched fields 0.

Verification
REQ-022 Nominal: vsew=2, vl=40, vd=8, vs1=16, vs2=24, iss_ready=1 -> 3 beats:
- iss_elem_cnt 16, 16, 8;
- iss_vd 8, 9, 10 and iss_vs2 24, 25, 26;
- iss_last only on beat 3;
- done in the cycle after beat 3.
REQ-023 Zero length: vl=0, vsew=0 -> no iss_valid; done=1 at T+1; in_ready=1 at T+2.
REQ-024 Illegal SEW: vsew=5, vl=10 -> err=1 and done=1 at T+1; no beats issued.
REQ-025 Clamp and wrap: vsew=0, vl=1000, vd=28 -> 8 beats of 64 elements; iss_vd 28, 29, 30, 31, 0, 1, 2, 3.
REQ-026 Backpressure: iss_ready low for 3 cycles during beat 2 -> beat 2 fields held stable for 4 cycles; no beat skipped or duplicated.
REQ-027 Abort paths: kill during beat 2 of a 3-beat instruction -> IDLE next cycle, no done; separately, rst pulse during ISSUE -> all outputs at reset values immediately.
